regfile_mp: RTL

Parametrised multi-port register file for the pipelined ARM core. It replaces the single-write, two-read uniciclo register file and adds:
- NRD combinational read ports with R15 substitution.
- Two write ports: ALU result and load writeback.
- Optional write-to-read bypass.
- A pending-load scoreboard for hazard detection.
- A sequenced clear engine.
It sits between decode (reads, busy check) and writeback (writes).

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_mp_if.sv | 37 +++
 rtl/regfile_scoreboard.sv | 59 +++++
 rtl/regfile_mp.sv | 139 +++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file slice.
package regfile_pkg;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DATA_W_DEF = 32;
  localparam int NREGS_DEF  = 16;
  localparam int AW_DEF     = addr_w(NREGS_DEF);

  typedef logic [AW_DEF-1:0]     reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bundle of the register file: reads, writes, reservations, clear.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int NRD    = 3
);
  localparam int AW = addr_w(NREGS);

  logic [NRD-1:0][AW-1:0]       ra;
  logic [NRD-1:0][DATA_W-1:0]   rd;
  logic [NRD-1:0]               busy;
  logic                         we_a;
  logic [AW-1:0]                wa_a;
  logic [DATA_W-1:0]            wd_a;
  logic                         we_b;
  logic [AW-1:0]                wa_b;
  logic [DATA_W-1:0]            wd_b;
  logic [DATA_W-1:0]            r15;
  logic                         rsv_en;
  logic [AW-1:0]                rsv_addr;
  logic                         clr_req;
  logic                         clr_busy;
  logic [NREGS-2:0][DATA_W-1:0] registers;

  modport master (
    output ra, we_a, wa_a, wd_a, we_b, wa_b, wd_b, r15, rsv_en, rsv_addr, clr_req,
    input  rd, busy, clr_busy, registers
  );

  modport slave (
    input  ra, we_a, wa_a, wd_a, we_b, wa_b, wd_b, r15, rsv_en, rsv_addr, clr_req,
    output rd, busy, clr_busy, registers
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one bit per register, set by reservations, cleared by load writeback.
module regfile_scoreboard #(
  parameter int NREGS  = 16,
  parameter int NRD    = 3,
  parameter int PC_IDX = 15,
  parameter int BYPASS = 1,
  parameter int AW     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   hold,
  input  logic                   set_en,
  input  logic [AW-1:0]          set_addr,
  input  logic                   clr_en,
  input  logic [AW-1:0]          clr_addr,
  input  logic [NRD-1:0][AW-1:0] ra,
  output logic [NRD-1:0]         busy
);

  localparam logic [AW-1:0] PC_A     = AW'(PC_IDX);
  localparam logic [AW:0]   NREGS_A  = (AW+1)'(NREGS);

  logic [NREGS-1:0] pending_q, pending_d;

  // Set beats clear so a fresh load to the same register stays pending.
  always_comb begin
    pending_d = pending_q;
    for (int j = 0; j < NREGS; j++) begin
      if (flush) begin
        pending_d[j] = 1'b0;
      end else if (set_en && set_addr == AW'(j)) begin
        pending_d[j] = 1'b1;
      end else if (clr_en && clr_addr == AW'(j)) begin
        pending_d[j] = 1'b0;
      end
    end
    pending_d[PC_IDX] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (!hold && ra[i] != PC_A && {1'b0, ra[i]} < NREGS_A &&
          !((BYPASS != 0) && clr_en && clr_addr == ra[i])) begin
        busy[i] = pending_q[ra[i]];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NRD read ports with PC substitution and
// optional bypass, pending-load scoreboard, and a one-register-per-cycle clear engine.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int NRD    = 3,
  parameter int PC_IDX = 15,
  parameter int BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_mp_if.slave bus
);

  localparam int AW  = addr_w(NREGS);
  // Stored registers are 0..NREGS-2; PC_IDX is expected to be the top index.
  localparam int NST = NREGS - 1;
  localparam logic [AW-1:0] PC_A   = AW'(PC_IDX);
  localparam logic [AW-1:0] LAST_A = AW'(NREGS - 2);
  localparam logic [AW:0]   NST_A  = (AW+1)'(NST);

  logic [DATA_W-1:0] rf_q [NST];
  logic [DATA_W-1:0] rf_d [NST];

  clr_state_e    state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic          clearing;
  logic          flush;
  logic          we_a_e, we_b_e, rsv_e;

  assign clearing = (state_q == CLEAR);
  assign we_a_e   = bus.we_a   & ~clearing;
  assign we_b_e   = bus.we_b   & ~clearing;
  assign rsv_e    = bus.rsv_en & ~clearing;
  assign bus.clr_busy = clearing;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    flush     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
          flush     = 1'b1;
        end
      end
      CLEAR: begin
        if (clr_idx_q == LAST_A) begin
          state_d   = IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        clr_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Port B is applied after port A so it wins a same-address collision.
  always_comb begin
    for (int j = 0; j < NST; j++) begin
      rf_d[j] = rf_q[j];
      if (clearing) begin
        if (clr_idx_q == AW'(j)) rf_d[j] = '0;
      end else begin
        if (we_a_e && bus.wa_a == AW'(j) && j != PC_IDX) rf_d[j] = bus.wd_a;
        if (we_b_e && bus.wa_b == AW'(j) && j != PC_IDX) rf_d[j] = bus.wd_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NST; j++) rf_q[j] <= '0;
    end else begin
      for (int j = 0; j < NST; j++) rf_q[j] <= rf_d[j];
    end
  end

  always_comb begin
    bus.rd = '0;
    for (int i = 0; i < NRD; i++) begin
      if (bus.ra[i] == PC_A) begin
        bus.rd[i] = bus.r15;
      end else if ({1'b0, bus.ra[i]} < NST_A) begin
        if ((BYPASS != 0) && we_b_e && bus.wa_b == bus.ra[i]) begin
          bus.rd[i] = bus.wd_b;
        end else if ((BYPASS != 0) && we_a_e && bus.wa_a == bus.ra[i]) begin
          bus.rd[i] = bus.wd_a;
        end else begin
          bus.rd[i] = rf_q[bus.ra[i]];
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NST; gi++) begin : g_dbg
      assign bus.registers[gi] = rf_q[gi];
    end
  endgenerate

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .PC_IDX (PC_IDX),
    .BYPASS (BYPASS),
    .AW     (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .hold     (clearing),
    .set_en   (rsv_e),
    .set_addr (bus.rsv_addr),
    .clr_en   (we_b_e),
    .clr_addr (bus.wa_b),
    .ra       (bus.ra),
    .busy     (bus.busy)
  );

endmodule
